add_seq_arb: RTL and testbench
==============================

# add_seq_arb

Sequencing controller and two-requester arbiter for a single shared `add_4` slice. It adds two W-bit operands (W = 4·NIBBLES) nibble-serially, one nibble per clock, with the carry registered between nibbles. Two clients share the slice under round-robin arbitration, and each result is returned on a valid/ready output port tagged with the requester ID. It sits between the client datapaths and the one `add_4` instance it owns.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; W = 4·NIBBLES; legal range ≥ 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req0_valid` in 1: requester 0 has an operation pending.
- `req0_ready` out 1: requester 0 granted; handshake when `req0_valid & req0_ready`.
- `req0_a`, `req0_b` in W: requester 0 operands.
- `req0_cin` in 1: requester 0 carry-in.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cin`: same as requester 0, for requester 1.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result when `res_valid & res_ready`.
- `res_sum` out W: (A + B + cin) mod 2^W.
- `res_cout` out 1: carry out of the MSB nibble.
- `res_id` out 1: requester that issued this result.

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE:**
  - Grant at most one requester; its ready = 1, the other's = 0.
  - If both are valid, the requester named by the priority pointer wins.
  - If only one is valid, that one wins regardless of the pointer.
  - If neither is valid, both readies are 0.
  - On handshake: latch A, B, cin and ID; clear nibble index and `res_sum`; set the pointer to the non-granted requester; go to CALC.
- **CALC:**
  - The `add_4` gets nibble[idx] of A and B.
  - Its carry-in is the latched cin when idx = 0, otherwise the carry register.
  - Write its SUM to `res_sum[4·idx+3:4·idx]` and its COUT to the carry register.
  - idx increments each cycle.
  - At idx = NIBBLES−1, also load `res_cout` from COUT and go to DONE.
- **DONE:** `res_valid` = 1, and `res_sum`, `res_cout` and `res_id` hold stable. On `res_ready`, return to IDLE.
- **Ready outside IDLE:** both readies are 0 in CALC, DONE and during reset. No operation is accepted while a result is pending.
- **Requester obligations:** hold valid and operands until ready. After the handshake, input changes have no effect.
- **Width/overflow:** the sum wraps modulo 2^W, with overflow reported only via `res_cout`. Signed overflow is not flagged.
- **Reset:**
  - state = IDLE, `res_valid` = 0, `res_sum` = 0, `res_cout` = 0, `res_id` = 0.
  - carry register = 0, idx = 0, pointer = requester 0.
  - Both readies are 0 while reset is high.
- **Reset mid-operation:** the in-flight operation is dropped silently and no result is produced. The next operation is unaffected; the carry is cleared.

## Timing
- The acceptance edge is E0. CALC occupies edges E1..E_NIBBLES. `res_valid` is high in the cycle after E_NIBBLES, i.e. NIBBLES cycles after E0 (4 at the default).
- With `res_ready` tied high, `res_valid` is high for exactly 1 cycle. The next acceptance can occur in the IDLE cycle that follows, so minimum issue-to-issue is NIBBLES+2 cycles.
- Ready is combinational from state, pointer and the valids. No combinational path exists from `res_ready` to any output.
- `res_valid` depends only on registered state.

## Test plan
1. **Single req0:** req0 issues A=0x1234, B=0x1111, cin=0. Expect `res_sum`=0x2345, `res_cout`=0, `res_id`=0, with `res_valid` rising exactly 4 cycles after the handshake.
2. **Full ripple:** req1 issues A=0xFFFF, B=0x0000, cin=1. Expect `res_sum`=0x0000, `res_cout`=1, `res_id`=1; the carry propagates through all four nibbles.
3. **Contention, `res_ready`=1:**
   - Both requesters stay valid for 4 operations.
   - Expect grants in the order 0,1,0,1.
   - req1 operands A=0x8000, B=0x8000 give 0x0000 with cout 1.
   - req0 operands A=0x00FF, B=0x0001 give 0x0100 with cout 0.
   - Expect issue spacing of 6 cycles.
4. **Backpressure:** hold `res_ready`=0 for 5 cycles in DONE. Expect `res_valid`, `res_sum`, `res_cout` and `res_id` stable; both readies 0; no acceptance. Raise `res_ready` and expect return to IDLE the next cycle.
5. **Reset in CALC:** assert reset after 2 nibbles. Expect all outputs at reset values next cycle and no result. Then issue A=0x000F, B=0x0001 from req0 and expect 0x0010, cout 0, with priority back at req0.
6. **Lone requester:** with the pointer at req0, only req1 is valid. Expect `req1_ready`=1 in the same cycle, immediate acceptance, and the pointer moving to req0.

Source files
------------

// File: rtl/add_seq_arb.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// add_4
// One nibble slice of a ripple adder: {cout, sum} = a + b + cin.
//   a, b  : 4-bit operand nibbles
//   cin   : carry into the nibble
//   sum   : 4-bit nibble sum
//   cout  : carry out of the nibble
// ---------------------------------------------------------------------------
module add_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    // Widen to 5 bits so the carry falls out of the top bit.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// ---------------------------------------------------------------------------
// add_seq_arb
// Shares one add_4 slice between two requesters. A granted operation is
// added one nibble per clock, LSB first, with the carry held in a register
// between nibbles. The result is presented on a valid/ready port together
// with the ID of the requester that issued it. Grants alternate round-robin
// when both requesters are waiting.
//
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   req0_valid / req0_ready  : requester 0 handshake
//   req0_a, req0_b, req0_cin : requester 0 operands and carry-in
//   req1_*                   : same for requester 1
//   res_valid / res_ready    : result handshake
//   res_sum                  : (A + B + cin) mod 2^W
//   res_cout                 : carry out of the most significant nibble
//   res_id                   : requester that issued the result
// ---------------------------------------------------------------------------
module add_seq_arb #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [4*NIBBLES-1:0] req0_a,
    input  logic [4*NIBBLES-1:0] req0_b,
    input  logic                 req0_cin,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [4*NIBBLES-1:0] req1_a,
    input  logic [4*NIBBLES-1:0] req1_b,
    input  logic                 req1_cin,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4*NIBBLES-1:0] res_sum,
    output logic                 res_cout,
    output logic                 res_id
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             cin_q;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic             ptr;
    logic             grant0;
    logic             grant1;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic             nib_cin;
    logic [3:0]       nib_sum;
    logic             nib_cout;

    // Arbitration. Only IDLE can accept, and reset masks both grants so no
    // handshake can be seen while the block is being cleared. With both
    // requesters waiting, ptr decides; a lone requester always wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset && state == ST_IDLE) begin
            if (req0_valid && (!req1_valid || !ptr)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign res_valid  = (state == ST_DONE);

    // The first nibble takes the requester's carry-in; later nibbles take
    // the carry registered from the previous nibble.
    assign nib_a   = a_q[{idx, 2'b00} +: 4];
    assign nib_b   = b_q[{idx, 2'b00} +: 4];
    assign nib_cin = (idx == '0) ? cin_q : carry;

    add_4 u_add_4 (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (nib_cin),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Sequencer: latch a granted operation, walk the nibbles, then hold the
    // result until the consumer takes it. The pointer always moves to the
    // requester that lost (or was absent), giving round-robin under load.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            carry    <= 1'b0;
            idx      <= '0;
            ptr      <= 1'b0;
            res_sum  <= '0;
            res_cout <= 1'b0;
            res_id   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant0 || grant1) begin
                        a_q     <= grant1 ? req1_a   : req0_a;
                        b_q     <= grant1 ? req1_b   : req0_b;
                        cin_q   <= grant1 ? req1_cin : req0_cin;
                        res_id  <= grant1;
                        ptr     <= grant0;
                        idx     <= '0;
                        res_sum <= '0;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    res_sum[{idx, 2'b00} +: 4] <= nib_sum;
                    carry <= nib_cout;
                    if (idx == LAST_IDX) begin
                        res_cout <= nib_cout;
                        idx      <= '0;
                        state    <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq_arb.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_add_seq_arb
// Directed scenarios followed by randomized traffic. A behavioural model
// (plain addition, a countdown to the result and a round-robin pointer)
// predicts readies, res_valid and the held result each cycle.
// ---------------------------------------------------------------------------
module tb_add_seq_arb;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         res_id;

    int vectors     = 0;
    int miscompares = 0;
    int cycle_count = 0;
    bit check_en    = 1'b0;

    // Reference model state
    int           exp_busy_left      = 0;
    bit           exp_result_pending = 1'b0;
    bit           exp_ptr            = 1'b0;
    logic [W-1:0] exp_sum            = '0;
    bit           exp_cout           = 1'b0;
    bit           exp_id             = 1'b0;
    bit           exp_r0;
    bit           exp_r1;
    bit           can_accept;
    logic [W:0]   full_sum;

    add_seq_arb #(.NIBBLES(NIBBLES)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit v0, input logic [W-1:0] a0,
                                 input logic [W-1:0] b0, input bit c0,
                                 input bit v1, input logic [W-1:0] a1,
                                 input logic [W-1:0] b1, input bit c1,
                                 input bit rr);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
        res_ready  = rr;
    endtask

    // Model: one comparison pass per cycle, then advance on the inputs that
    // will be sampled at the coming rising edge.
    always @(negedge clk) begin
        can_accept = !reset && exp_busy_left == 0 && !exp_result_pending;
        exp_r0 = 1'b0;
        exp_r1 = 1'b0;
        if (can_accept) begin
            if (req0_valid && req1_valid) begin
                exp_r0 = (exp_ptr == 1'b0);
                exp_r1 = (exp_ptr == 1'b1);
            end else begin
                exp_r0 = req0_valid;
                exp_r1 = req1_valid;
            end
        end
        if (check_en) begin
            checkOutput("req0_ready", req0_ready, exp_r0);
            checkOutput("req1_ready", req1_ready, exp_r1);
            checkOutput("res_valid", res_valid, exp_result_pending);
            if (exp_busy_left == 0) begin
                checkOutput("res_sum", res_sum, exp_sum);
                checkOutput("res_cout", res_cout, exp_cout);
                checkOutput("res_id", res_id, exp_id);
            end
        end
        if (reset) begin
            exp_busy_left      = 0;
            exp_result_pending = 1'b0;
            exp_ptr            = 1'b0;
            exp_sum            = '0;
            exp_cout           = 1'b0;
            exp_id             = 1'b0;
        end else if (exp_r0 || exp_r1) begin
            full_sum = exp_r1 ? ({1'b0, req1_a} + req1_b + req1_cin)
                              : ({1'b0, req0_a} + req0_b + req0_cin);
            exp_sum       = full_sum[W-1:0];
            exp_cout      = full_sum[W];
            exp_id        = exp_r1;
            exp_ptr       = exp_r0;
            exp_busy_left = NIBBLES;
        end else if (exp_busy_left > 0) begin
            exp_busy_left--;
            if (exp_busy_left == 0) exp_result_pending = 1'b1;
        end else if (exp_result_pending && res_ready) begin
            exp_result_pending = 1'b0;
        end
    end

    task automatic waitResult(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            seen = res_valid;
        end
        checkOutput({tag, " result_arrived"}, seen, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && res_valid; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    // Issue one operation, then check latency and the literal result.
    task automatic runOp(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit cin, input string tag,
                         input logic [W-1:0] exp_s, input bit exp_c);
        bit seen = 1'b0;
        int lat  = 0;
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = id ? req1_ready : req0_ready;
        end
        checkOutput({tag, " grant"}, seen, 1);
        @(posedge clk); #1;
        // Operands change after acceptance and must not affect the result.
        if (id == 1'b0) begin
            req0_valid = 1'b0; req0_a = W'($urandom); req0_b = W'($urandom);
            req0_cin = 1'($urandom);
        end else begin
            req1_valid = 1'b0; req1_a = W'($urandom); req1_b = W'($urandom);
            req1_cin = 1'($urandom);
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            seen = res_valid;
        end
        checkOutput({tag, " latency"}, lat, NIBBLES);
        checkOutput({tag, " sum"}, res_sum, exp_s);
        checkOutput({tag, " cout"}, res_cout, exp_c);
        checkOutput({tag, " id"}, res_id, id);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int hs_cycle[$];
        int hs_id[$];
        bit hs0;
        bit hs1;
        bit seen;

        reset = 1'b1;
        applyStimulus(0, '0, '0, 0, 0, '0, '0, 0, 1);
        @(posedge clk);
        check_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset res_valid", res_valid, 0);
        checkOutput("reset res_sum", res_sum, 0);
        checkOutput("reset res_cout", res_cout, 0);
        checkOutput("reset res_id", res_id, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single req0, then full ripple from req1.
        runOp(0, 16'h1234, 16'h1111, 0, "single_req0", 16'h2345, 0);
        drain();
        runOp(1, 16'hFFFF, 16'h0000, 1, "full_ripple", 16'h0000, 1);
        drain();

        // Contention with both valid: grants alternate, 6 cycles apart.
        applyStimulus(1, 16'h00FF, 16'h0001, 0, 1, 16'h8000, 16'h8000, 0, 1);
        for (int i = 0; i < 100 && hs_id.size() < 4; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) begin hs_cycle.push_back(cycle_count); hs_id.push_back(0); end
            if (req1_valid && req1_ready) begin hs_cycle.push_back(cycle_count); hs_id.push_back(1); end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkOutput("contention grant_count", hs_id.size(), 4);
        if (hs_id.size() == 4) begin
            checkOutput("contention order0", hs_id[0], 0);
            checkOutput("contention order1", hs_id[1], 1);
            checkOutput("contention order2", hs_id[2], 0);
            checkOutput("contention order3", hs_id[3], 1);
            for (int k = 1; k < 4; k++)
                checkOutput("contention spacing", hs_cycle[k] - hs_cycle[k-1], NIBBLES + 2);
        end
        waitResult("contention");
        checkOutput("contention last sum", res_sum, 16'h0000);
        checkOutput("contention last cout", res_cout, 1);
        checkOutput("contention last id", res_id, 1);
        drain();

        // Backpressure: result held, no acceptance while pending.
        res_ready = 1'b0;
        runOp(0, 16'hABCD, 16'h1234, 1, "backpressure", 16'hBE02, 0);
        req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp res_valid", res_valid, 1);
            checkOutput("bp req0_ready", req0_ready, 0);
            checkOutput("bp res_sum", res_sum, 16'hBE02);
            checkOutput("bp res_id", res_id, 0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp release res_valid", res_valid, 0);
        checkOutput("bp release idle_ready", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        waitResult("bp_second");
        checkOutput("bp_second sum", res_sum, 16'h0003);
        drain();

        // Reset during CALC after two nibbles.
        req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = req0_ready; end
        checkOutput("rst_calc grant", seen, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_calc res_valid", res_valid, 0);
        checkOutput("rst_calc res_sum", res_sum, 0);
        checkOutput("rst_calc res_cout", res_cout, 0);
        checkOutput("rst_calc res_id", res_id, 0);
        checkOutput("rst_calc req0_ready", req0_ready, 0);
        checkOutput("rst_calc req1_ready", req1_ready, 0);
        reset = 1'b0;
        req0_a = 16'h000F; req0_b = 16'h0001; req0_cin = 1'b0;
        @(negedge clk);
        checkOutput("after_rst ptr req0_ready", req0_ready, 1);
        checkOutput("after_rst ptr req1_ready", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        waitResult("after_rst");
        checkOutput("after_rst sum", res_sum, 16'h0010);
        checkOutput("after_rst cout", res_cout, 0);
        checkOutput("after_rst id", res_id, 0);
        drain();

        // Lone requester: bring the pointer to req0, then only req1 asks.
        runOp(1, 16'h0101, 16'h0202, 0, "ptr_setup", 16'h0303, 0);
        drain();
        req1_valid = 1'b1; req1_a = 16'h7FFF; req1_b = 16'h0001; req1_cin = 1'b0;
        @(negedge clk);
        checkOutput("lone req1_ready", req1_ready, 1);
        checkOutput("lone req0_ready", req0_ready, 0);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        waitResult("lone");
        checkOutput("lone sum", res_sum, 16'h8000);
        checkOutput("lone id", res_id, 1);
        drain();
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        checkOutput("lone ptr req0_ready", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();
        drain();

        // Randomized traffic with backpressure and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (!req0_valid || hs0) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
            end
            if (!req1_valid || hs1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
            end
            res_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 99) == 0);
        end

        reset = 1'b0;
        applyStimulus(0, '0, '0, 0, 0, '0, '0, 0, 1);
        repeat (10) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
